// File: rtl/video_scale_tracker.sv
// Raster-to-world-map address tracker: incremental sub-pixel counters, 2-clock latency.
// Optional horizontal mirroring of the emitted column when VSCALE_HFLIP_EN is defined.
module video_scale_tracker #(
  parameter int DISP_W    = 1024,
  parameter int DISP_H    = 768,
  parameter int MAP_W     = 128,
  parameter int MAP_H     = 128,
  parameter int COL_SCALE = 8,
  parameter int ROW_SCALE = 6,
  parameter int ADDR_W    = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pix_valid,
  input  logic [11:0]       pixel_row,
  input  logic [11:0]       pixel_col,
`ifdef VSCALE_HFLIP_EN
  input  logic              hflip,
`endif
  output logic [ADDR_W-1:0] vid_addr,
  output logic              addr_valid,
  output logic              out_of_map,
  output logic              locked,
  output logic              sync_err
);

  localparam int CB  = $clog2(MAP_W);
  localparam int RB  = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int CSW = (COL_SCALE > 1) ? $clog2(COL_SCALE) : 1;
  localparam int RSW = (ROW_SCALE > 1) ? $clog2(ROW_SCALE) : 1;
  // One spare bit so the indices can saturate at MAP_W / MAP_H.
  localparam int CIW = CB + 1;
  localparam int RIW = RB + 1;

  localparam logic [12:0]    DISP_W_L    = 13'(DISP_W);
  localparam logic [12:0]    DISP_H_L    = 13'(DISP_H);
  localparam logic [CSW-1:0] COL_SUB_MAX = CSW'(COL_SCALE - 1);
  localparam logic [RSW-1:0] ROW_SUB_MAX = RSW'(ROW_SCALE - 1);
  localparam logic [CIW-1:0] COL_IDX_SAT = CIW'(MAP_W);
  localparam logic [RIW-1:0] ROW_IDX_SAT = RIW'(MAP_H);
  localparam logic [CB-1:0]  COL_LAST    = CB'(MAP_W - 1);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [11:0]       last_row_q, last_row_d;
  logic [11:0]       last_col_q, last_col_d;
  logic [CSW-1:0]    col_sub_q, col_sub_d;
  logic [CIW-1:0]    col_idx_q, col_idx_d;
  logic [RSW-1:0]    row_sub_q, row_sub_d;
  logic [RIW-1:0]    row_idx_q, row_idx_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_err_q, s1_err_d;
  logic              s1_flip_q, s1_flip_d;
  logic [ADDR_W-1:0] vid_addr_q, vid_addr_d;
  logic              addr_valid_q, addr_valid_d;
  logic              out_of_map_q, out_of_map_d;
  logic              sync_err_q, sync_err_d;

  logic is_locked;
  logic is_origin;
  logic frame_start;
  logic in_range;
  logic col_next;
  logic row_next;
  logic step_col;
  logic step_row;
  logic discont;
  logic map_out;
  logic [CB-1:0] col_emit;

  // Raster event decode: only three moves keep the lock.
  assign is_locked   = (state_q == ST_LOCKED);
  assign is_origin   = (pixel_row == 12'd0) && (pixel_col == 12'd0);
  assign frame_start = pix_valid && is_origin;
  assign in_range    = ({1'b0, pixel_row} < DISP_H_L) && ({1'b0, pixel_col} < DISP_W_L);
  assign col_next    = ({1'b0, pixel_col} == ({1'b0, last_col_q} + 13'd1));
  assign row_next    = ({1'b0, pixel_row} == ({1'b0, last_row_q} + 13'd1));
  assign step_col    = is_locked && pix_valid && in_range && !is_origin
                       && (pixel_row == last_row_q) && col_next;
  assign step_row    = is_locked && pix_valid && in_range
                       && (pixel_col == 12'd0) && row_next;
  assign discont     = is_locked && pix_valid && !frame_start && !step_col && !step_row;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_UNLOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = ST_LOCKED;
    end else if (discont) begin
      state_d = ST_UNLOCKED;
    end
  end

  always_comb begin
    locked = (state_q == ST_LOCKED);
  end

  // Stage 1: sub-pixel counters follow the raster; indices saturate past the map.
  always_comb begin
    last_row_d = last_row_q;
    last_col_d = last_col_q;
    col_sub_d  = col_sub_q;
    col_idx_d  = col_idx_q;
    row_sub_d  = row_sub_q;
    row_idx_d  = row_idx_q;
    if (frame_start) begin
      last_row_d = 12'd0;
      last_col_d = 12'd0;
      col_sub_d  = '0;
      col_idx_d  = '0;
      row_sub_d  = '0;
      row_idx_d  = '0;
    end else if (step_col) begin
      last_col_d = pixel_col;
      if (col_sub_q == COL_SUB_MAX) begin
        col_sub_d = '0;
        if (col_idx_q < COL_IDX_SAT) begin
          col_idx_d = col_idx_q + CIW'(1);
        end
      end else begin
        col_sub_d = col_sub_q + CSW'(1);
      end
    end else if (step_row) begin
      last_row_d = pixel_row;
      last_col_d = 12'd0;
      col_sub_d  = '0;
      col_idx_d  = '0;
      if (row_sub_q == ROW_SUB_MAX) begin
        row_sub_d = '0;
        if (row_idx_q < ROW_IDX_SAT) begin
          row_idx_d = row_idx_q + RIW'(1);
        end
      end else begin
        row_sub_d = row_sub_q + RSW'(1);
      end
    end
  end

  assign s1_valid_d = frame_start || step_col || step_row;
  assign s1_err_d   = discont;
`ifdef VSCALE_HFLIP_EN
  assign s1_flip_d  = hflip;
`else
  assign s1_flip_d  = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_row_q <= 12'd0;
      last_col_q <= 12'd0;
      col_sub_q  <= '0;
      col_idx_q  <= '0;
      row_sub_q  <= '0;
      row_idx_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_flip_q  <= 1'b0;
    end else begin
      last_row_q <= last_row_d;
      last_col_q <= last_col_d;
      col_sub_q  <= col_sub_d;
      col_idx_q  <= col_idx_d;
      row_sub_q  <= row_sub_d;
      row_idx_q  <= row_idx_d;
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
      s1_flip_q  <= s1_flip_d;
    end
  end

  // Stage 2: bounds use the unmirrored index; mirroring only affects the emitted column.
  assign map_out  = (col_idx_q >= COL_IDX_SAT) || (row_idx_q >= ROW_IDX_SAT);
  assign col_emit = s1_flip_q ? (COL_LAST - col_idx_q[CB-1:0]) : col_idx_q[CB-1:0];

  always_comb begin
    vid_addr_d   = vid_addr_q;
    addr_valid_d = 1'b0;
    out_of_map_d = 1'b0;
    sync_err_d   = s1_err_q;
    if (s1_valid_q) begin
      if (map_out) begin
        out_of_map_d = 1'b1;
        vid_addr_d   = '0;
      end else begin
        addr_valid_d = 1'b1;
        vid_addr_d   = ADDR_W'({row_idx_q[RB-1:0], col_emit});
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vid_addr_q   <= '0;
      addr_valid_q <= 1'b0;
      out_of_map_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      vid_addr_q   <= vid_addr_d;
      addr_valid_q <= addr_valid_d;
      out_of_map_q <= out_of_map_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign vid_addr   = vid_addr_q;
  assign addr_valid = addr_valid_q;
  assign out_of_map = out_of_map_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_video_scale_tracker.sv
// Bench for video_scale_tracker: a default-width instance and a 1280-wide instance
// driven in parallel, checked against an arithmetic raster model plus a vector table.
module tb_video_scale_tracker;

`ifdef VSCALE_HFLIP_EN
  localparam bit HF_ON = 1'b1;
`else
  localparam bit HF_ON = 1'b0;
`endif
  localparam int DW0 = 1024;
  localparam int DW1 = 1280;

  logic              clk;
  logic              resetn;
  logic              pix_valid;
  logic [11:0]       pixel_row;
  logic [11:0]       pixel_col;
  logic              hflip;
  logic [1:0][13:0]  o_addr;
  logic [1:0]        o_av;
  logic [1:0]        o_oom;
  logic [1:0]        o_lock;
  logic [1:0]        o_err;

  video_scale_tracker u_a (
    .clk        (clk),
    .resetn     (resetn),
    .pix_valid  (pix_valid),
    .pixel_row  (pixel_row),
    .pixel_col  (pixel_col),
`ifdef VSCALE_HFLIP_EN
    .hflip      (hflip),
`endif
    .vid_addr   (o_addr[0]),
    .addr_valid (o_av[0]),
    .out_of_map (o_oom[0]),
    .locked     (o_lock[0]),
    .sync_err   (o_err[0])
  );

  video_scale_tracker #(.DISP_W(DW1)) u_b (
    .clk        (clk),
    .resetn     (resetn),
    .pix_valid  (pix_valid),
    .pixel_row  (pixel_row),
    .pixel_col  (pixel_col),
`ifdef VSCALE_HFLIP_EN
    .hflip      (hflip),
`endif
    .vid_addr   (o_addr[1]),
    .addr_valid (o_av[1]),
    .out_of_map (o_oom[1]),
    .locked     (o_lock[1]),
    .sync_err   (o_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    bit          av;
    bit          oom;
    bit          err;
    logic [13:0] addr;
    int          tag;
    int          row;
    int          col;
    bit          hf;
  } exp_t;

  typedef struct {
    bit          v;
    int          row;
    int          col;
    bit          av;
    bit          oom;
    logic [13:0] addr;
    bit          err;
    bit          lock;
  } vec_t;

  int          n_cmp;
  int          n_bad;
  vec_t        vecs [48];
  int          nvec;

  bit          m_lock [2];
  int          m_lr   [2];
  int          m_lc   [2];
  logic [13:0] m_addr [2];
  exp_t        p1     [2];
  exp_t        p2     [2];
  bit          lk1    [2];
  bit          lk_chk [2];

  task automatic chk(input string name, input int d, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %0d, expected %0d", name, d, $time, act, exp);
    end
  endtask

  task automatic addv(input bit v, input int r, input int c, input bit av, input bit oom,
                      input int addr, input bit err, input bit lock);
    vecs[nvec].v    = v;
    vecs[nvec].row  = r;
    vecs[nvec].col  = c;
    vecs[nvec].av   = av;
    vecs[nvec].oom  = oom;
    vecs[nvec].addr = 14'(addr);
    vecs[nvec].err  = err;
    vecs[nvec].lock = lock;
    nvec++;
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      m_lock[d] = 1'b0;
      m_lr[d]   = 0;
      m_lc[d]   = 0;
      m_addr[d] = '0;
      p1[d]     = '{chk: 1'b1, av: 1'b0, oom: 1'b0, err: 1'b0, addr: '0, tag: -1, row: 0, col: 0, hf: 1'b0};
      p2[d]     = p1[d];
      lk1[d]    = 1'b0;
      lk_chk[d] = 1'b1;
    end
  endtask

  // Reference: once locked, the raster has visited every column from 0 on this line and
  // every row from 0 in this frame, so map cell = (row / ROW_SCALE, col / COL_SCALE).
  task automatic model_step(input int d, input bit v, input int r, input int c, input bit hf,
                            output exp_t e);
    int  dw;
    int  ci;
    int  ri;
    bit  legal;
    e = '{chk: 1'b1, av: 1'b0, oom: 1'b0, err: 1'b0, addr: '0, tag: -1, row: r, col: c, hf: hf && HF_ON};
    dw = (d == 0) ? DW0 : DW1;
    if (v) begin
      legal = m_lock[d] && (r < 768) && (c < dw)
              && (((r == m_lr[d]) && (c == m_lc[d] + 1)) || ((c == 0) && (r == m_lr[d] + 1)));
      if ((r == 0 && c == 0) || legal) begin
        m_lock[d] = 1'b1;
        m_lr[d]   = r;
        m_lc[d]   = c;
        ci = c / 8;
        ri = r / 6;
        if (ci >= 128 || ri >= 128) begin
          e.oom     = 1'b1;
          m_addr[d] = '0;
        end else begin
          e.av      = 1'b1;
          m_addr[d] = 14'(ri * 128 + ((hf && HF_ON) ? (127 - ci) : ci));
        end
      end else begin
        e.err     = m_lock[d];
        m_lock[d] = 1'b0;
      end
    end
    e.addr = m_addr[d];
  endtask

  task automatic pin_check(input int d, input exp_t e);
    bit          hit;
    logic [13:0] want;
    hit  = 1'b0;
    want = '0;
    if (!e.hf) begin
      if (e.row == 0 && e.col == 0)         begin hit = 1'b1; want = 14'd0;     end
      else if (e.row == 5 && e.col == 7)    begin hit = 1'b1; want = 14'd0;     end
      else if (e.row == 6 && e.col == 8)    begin hit = 1'b1; want = 14'd129;   end
      else if (e.row == 767 && e.col == 1023) begin hit = 1'b1; want = 14'd16383; end
    end else begin
      if (e.row == 0 && e.col == 0)         begin hit = 1'b1; want = 14'd127;   end
      else if (e.row == 0 && e.col == 1023) begin hit = 1'b1; want = 14'd0;     end
      else if (e.row == 6 && e.col == 8)    begin hit = 1'b1; want = 14'd254;   end
    end
    if (hit) chk("pinned_addr", d, o_addr[d], want);
  endtask

  // One clock: check what is due, then present the next pixel.
  task automatic cycle(input bit v, input int r, input int c, input bit hf, input int tag);
    exp_t e;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (lk_chk[d]) chk("locked", d, o_lock[d], lk1[d]);
      if (p2[d].chk) begin
        chk("addr_valid", d, o_av[d], p2[d].av);
        chk("out_of_map", d, o_oom[d], p2[d].oom);
        chk("sync_err", d, o_err[d], p2[d].err);
        chk("vid_addr", d, o_addr[d], p2[d].addr);
        if (p2[d].av) pin_check(d, p2[d]);
        if (d == 0 && p2[d].tag >= 0)
          $display("vec %0d (%0d,%0d): addr=%0d av=%0b oom=%0b err=%0b", p2[d].tag,
                   p2[d].row, p2[d].col, o_addr[0], o_av[0], o_oom[0], o_err[0]);
      end
    end
    pix_valid = v;
    pixel_row = 12'(r);
    pixel_col = 12'(c);
    hflip     = hf;
    for (int d = 0; d < 2; d++) begin
      model_step(d, v, r, c, hf, e);
      lk1[d] = m_lock[d];
      if (d == 0 && tag >= 0) begin
        e.av   = vecs[tag].av;
        e.oom  = vecs[tag].oom;
        e.addr = vecs[tag].addr;
        e.err  = vecs[tag].err;
        e.tag  = tag;
        lk1[d] = vecs[tag].lock;
      end
      p2[d]     = p1[d];
      p1[d]     = e;
      lk_chk[d] = 1'b1;
    end
  endtask

  task automatic px(input int r, input int c, input bit hf);
    cycle(1'b1, r, c, hf, -1);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0, -1);
  endtask

  // Shortened legal raster: lines may end early, so row 767 is reached via column 0 only.
  task automatic raster_walk(input bit hf);
    for (int c = 0; c < 16; c++) px(0, c, hf);
    for (int r = 1; r < 5; r++) px(r, 0, hf);
    for (int c = 0; c < 8; c++) px(5, c, hf);
    for (int c = 0; c < 9; c++) px(6, c, hf);
    for (int r = 7; r < 768; r++) px(r, 0, hf);
    for (int c = 1; c < 1024; c++) px(767, c, hf);
    blank(2);
  endtask

  initial begin
    int p;
    int r;
    int c;
    n_cmp = 0;
    n_bad = 0;
    nvec  = 0;
    for (int d = 0; d < 2; d++) begin
      p1[d].chk = 1'b0;
      p2[d].chk = 1'b0;
      lk_chk[d] = 1'b0;
    end

    // Vector table: mid-frame start, lock, blanking hold, sub-pixel wrap, jumps.
    addv(1'b1, 100, 5, 1'b0, 1'b0,   0, 1'b0, 1'b0);
    addv(1'b1, 100, 6, 1'b0, 1'b0,   0, 1'b0, 1'b0);
    addv(1'b1,   0, 0, 1'b1, 1'b0,   0, 1'b0, 1'b1);
    addv(1'b1,   0, 1, 1'b1, 1'b0,   0, 1'b0, 1'b1);
    addv(1'b0,   0, 0, 1'b0, 1'b0,   0, 1'b0, 1'b1);
    addv(1'b1,   0, 2, 1'b1, 1'b0,   0, 1'b0, 1'b1);
    for (int i = 1; i <= 6; i++) addv(1'b1, i, 0, 1'b1, 1'b0, (i == 6) ? 128 : 0, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) addv(1'b1, 6, i, 1'b1, 1'b0, (i == 8) ? 129 : 128, 1'b0, 1'b1);
    addv(1'b1,   6, 10, 1'b0, 1'b0, 129, 1'b1, 1'b0);
    addv(1'b1,   6, 11, 1'b0, 1'b0, 129, 1'b0, 1'b0);
    addv(1'b1,   0, 0, 1'b1, 1'b0,   0, 1'b0, 1'b1);
    addv(1'b1,   5, 0, 1'b0, 1'b0,   0, 1'b1, 1'b0);
    addv(1'b1,   0, 0, 1'b1, 1'b0,   0, 1'b0, 1'b1);
    addv(1'b1,   0, 1, 1'b1, 1'b0,   0, 1'b0, 1'b1);

    resetn    = 1'b0;
    pix_valid = 1'b0;
    pixel_row = '0;
    pixel_col = '0;
    hflip     = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_addr", d, o_addr[d], 0);
      chk("reset_av", d, o_av[d], 0);
      chk("reset_oom", d, o_oom[d], 0);
      chk("reset_lock", d, o_lock[d], 0);
      chk("reset_err", d, o_err[d], 0);
    end
    reset_model();
    resetn = 1'b1;

    for (int i = 0; i < nvec; i++) cycle(vecs[i].v, vecs[i].row, vecs[i].col, 1'b0, i);
    blank(2);

    raster_walk(1'b0);

    // Column jump 500 -> 502 on row 10, then relock at the next frame start.
    px(0, 0, 1'b0);
    for (int i = 1; i <= 10; i++) px(i, 0, 1'b0);
    for (int i = 1; i <= 500; i++) px(10, i, 1'b0);
    for (int i = 502; i <= 510; i++) px(10, i, 1'b0);
    blank(1);
    px(0, 0, 1'b0);
    px(0, 1, 1'b0);
    px(1, 0, 1'b0);
    blank(2);

    // Full 1280-wide line: the wide instance goes out of map, the default one unlocks.
    for (int i = 0; i < 1280; i++) px(0, i, 1'b0);
    for (int i = 0; i < 3; i++) px(1, i, 1'b0);
    blank(2);

    // Asynchronous reset mid-line at row 300.
    px(0, 0, 1'b0);
    for (int i = 1; i <= 300; i++) px(i, 0, 1'b0);
    for (int i = 1; i <= 20; i++) px(300, i, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_rst_addr", d, o_addr[d], 0);
      chk("async_rst_av", d, o_av[d], 0);
      chk("async_rst_oom", d, o_oom[d], 0);
      chk("async_rst_lock", d, o_lock[d], 0);
      chk("async_rst_err", d, o_err[d], 0);
    end
    reset_model();
    px(300, 21, 1'b0);
    px(300, 22, 1'b0);
    resetn = 1'b1;
    for (int i = 23; i <= 30; i++) px(300, i, 1'b0);
    px(0, 0, 1'b0);
    px(0, 1, 1'b0);
    blank(2);

    if (HF_ON) raster_walk(1'b1);

    // Randomised raster traffic: mostly legal steps, with blanking, restarts and jumps.
    for (int i = 0; i < 3000; i++) begin
      p = $urandom_range(0, 99);
      if (p < 12) begin
        cycle(1'b0, 0, 0, 1'b0, -1);
      end else if (p < 75) begin
        if (!m_lock[0]) begin
          if ($urandom_range(0, 2) == 0) begin r = 0; c = 0; end
          else begin r = $urandom_range(0, 100); c = $urandom_range(0, 100); end
        end else if (m_lc[0] >= int'($urandom_range(20, 60))) begin
          r = m_lr[0] + 1; c = 0;
          if (r >= 768) r = 0;
        end else begin
          r = m_lr[0]; c = m_lc[0] + 1;
        end
        cycle(1'b1, r, c, 1'($urandom_range(0, 1)), -1);
      end else if (p < 85) begin
        cycle(1'b1, m_lr[0] + 1, 0, 1'($urandom_range(0, 1)), -1);
      end else if (p < 90) begin
        cycle(1'b1, 0, 0, 1'($urandom_range(0, 1)), -1);
      end else begin
        cycle(1'b1, $urandom_range(0, 800), $urandom_range(0, 1300), 1'($urandom_range(0, 1)), -1);
      end
    end
    blank(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
